// File: rtl/nor_share_arbiter.sv
// Round-robin arbiter that time-shares one external 2-input NOR gate among
// NUM_REQ requesters; every output is registered.
module nor_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] a_in,
   input  logic [NUM_REQ-1:0] b_in,
   output logic [NUM_REQ-1:0] ack,
   output logic               y_out,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     grant_id,
   output logic               busy,
   output logic               gate_a,
   output logic               gate_b,
   input  logic               gate_y
);

   localparam int unsigned        N   = NUM_REQ;
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   typedef enum logic [1:0] {IDLE, EVAL, ACK} state_t;

   state_t             state_q;
   logic [IDW-1:0]     ptr_q;
   logic [IDW-1:0]     grant_id_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [NUM_REQ-1:0] ack_q;
   logic               busy_q;
   logic               y_q;
   logic               gate_a_q;
   logic               gate_b_q;
   logic               result_q;
   logic               sampled_q;

   logic               sel_found_d;
   logic [IDW-1:0]     sel_d;
   logic [IDW-1:0]     ptr_d;

   // First requester at or above the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      logic [IDW-1:0] idx;
      sel_found_d = 1'b0;
      sel_d       = '0;
      idx         = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = IDW'((32'(ptr_q) + k) % N);
         if (!sel_found_d && req[idx]) begin
            sel_found_d = 1'b1;
            sel_d       = idx;
         end
      end
   end

   assign ptr_d = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + 1'b1;

   // EVAL spans two cycles: gate_y is sampled on the first edge and the
   // registered ack/y_out are launched on the second, so ACK is the ack cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         grant_id_q <= '0;
         grant_q    <= '0;
         ack_q      <= '0;
         busy_q     <= 1'b0;
         y_q        <= 1'b0;
         gate_a_q   <= 1'b0;
         gate_b_q   <= 1'b0;
         result_q   <= 1'b0;
         sampled_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel_found_d) begin
                  grant_q    <= ONE << sel_d;
                  grant_id_q <= sel_d;
                  busy_q     <= 1'b1;
                  gate_a_q   <= a_in[sel_d];
                  gate_b_q   <= b_in[sel_d];
                  sampled_q  <= 1'b0;
                  state_q    <= EVAL;
               end
            end
            EVAL: begin
               if (!sampled_q) begin
                  result_q  <= gate_y;
                  sampled_q <= 1'b1;
               end else begin
                  ack_q   <= ONE << grant_id_q;
                  y_q     <= result_q;
                  ptr_q   <= ptr_d;
                  state_q <= ACK;
               end
            end
            ACK: begin
               ack_q      <= '0;
               y_q        <= 1'b0;
               grant_q    <= '0;
               grant_id_q <= '0;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack      = ack_q;
   assign y_out    = y_q;
   assign grant    = grant_q;
   assign grant_id = grant_id_q;
   assign busy     = busy_q;
   assign gate_a   = gate_a_q;
   assign gate_b   = gate_b_q;

endmodule
